// File: rtl/hr_encoder_pipe.sv
// rtl/hr_encoder_pipe.sv - pipelined block header/residual encoder with credit-controlled output FIFO
// Optional HR_STATS_EN adds saturating popped-block and packed-bit counters.
`timescale 1ns/1ps

module hr_encoder_pipe #(
  parameter  int NPIX       = 16,
  parameter  int PIX_W      = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int BITS_W     = $clog2(PIX_W + 1),
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NPIX*PIX_W-1:0]   in_pixels,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PIX_W-1:0]        out_base,
  output logic [BITS_W-1:0]       out_bits,
  output logic [NPIX*PIX_W-1:0]   out_residuals,
  output logic [LVL_W-1:0]        fifo_level
`ifdef HR_STATS_EN
  ,
  output logic [31:0]             stat_blocks,
  output logic [31:0]             stat_bits
`endif
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DATA_W = NPIX * PIX_W;

  logic              s1_valid;
  logic              s2_valid;
  logic [DATA_W-1:0] s1_pix;
  logic [PIX_W-1:0]  s1_min;
  logic [PIX_W-1:0]  s1_max;
  logic [PIX_W-1:0]  s2_base;
  logic [BITS_W-1:0] s2_bits;
  logic [DATA_W-1:0] s2_res;

  logic [PIX_W-1:0]  in_min;
  logic [PIX_W-1:0]  in_max;
  logic [PIX_W-1:0]  diff;
  logic [BITS_W-1:0] bits_c;
  logic [DATA_W-1:0] res_c;

  logic [PIX_W-1:0]  mem_base [FIFO_DEPTH];
  logic [BITS_W-1:0] mem_bits [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_res  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;

  logic              accept;
  logic              push;
  logic              pop;
  logic [LVL_W+1:0]  credit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Every block in S1/S2 already holds a reserved FIFO slot, so the pipe never stalls.
  assign credit   = (LVL_W+2)'(count) + (LVL_W+2)'(s1_valid) + (LVL_W+2)'(s2_valid);
  assign in_ready = credit < (LVL_W+2)'(FIFO_DEPTH);
  assign accept   = in_valid & in_ready;
  assign push     = s2_valid;
  assign out_valid = (count != '0);
  assign pop      = out_valid & out_ready;
  assign fifo_level = count;

  always_comb begin
    in_min = in_pixels[PIX_W-1:0];
    in_max = in_pixels[PIX_W-1:0];
    for (int i = 1; i < NPIX; i++) begin
      if (in_pixels[i*PIX_W +: PIX_W] < in_min) in_min = in_pixels[i*PIX_W +: PIX_W];
      if (in_pixels[i*PIX_W +: PIX_W] > in_max) in_max = in_pixels[i*PIX_W +: PIX_W];
    end
  end

  // Residual width is the position of the highest set bit of the range, plus one.
  always_comb begin
    diff   = s1_max - s1_min;
    bits_c = '0;
    for (int b = 0; b < PIX_W; b++) begin
      if (diff[b]) bits_c = BITS_W'(b + 1);
    end
    res_c = '0;
    for (int i = 0; i < NPIX; i++) begin
      res_c[i*PIX_W +: PIX_W] = s1_pix[i*PIX_W +: PIX_W] - s1_min;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + LVL_W'(1);
      else if (pop && !push) count <= count - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_pix <= in_pixels;
      s1_min <= in_min;
      s1_max <= in_max;
    end
    if (s1_valid) begin
      s2_base <= s1_min;
      s2_bits <= bits_c;
      s2_res  <= res_c;
    end
    if (push) begin
      mem_base[wr_ptr] <= s2_base;
      mem_bits[wr_ptr] <= s2_bits;
      mem_res[wr_ptr]  <= s2_res;
    end
  end

  assign out_base      = mem_base[rd_ptr];
  assign out_bits      = mem_bits[rd_ptr];
  assign out_residuals = mem_res[rd_ptr];

`ifdef HR_STATS_EN
  logic [32:0] pack_size;
  logic [32:0] bits_sum;

  assign pack_size = 33'(PIX_W + BITS_W) + 33'(NPIX) * 33'(out_bits);
  assign bits_sum  = {1'b0, stat_bits} + pack_size;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_blocks <= '0;
      stat_bits   <= '0;
    end else if (pop) begin
      if (stat_blocks != 32'hFFFF_FFFF) stat_blocks <= stat_blocks + 32'd1;
      stat_bits <= bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_hr_encoder_pipe.sv
// tb/tb_hr_encoder_pipe.sv - self-checking bench for hr_encoder_pipe with a queue-based reference model
`timescale 1ns/1ps

module tb_hr_encoder_pipe;

  localparam int NPIX = 16;
  localparam int PIX_W = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BITS_W = 4;
  localparam int LVL_W = 3;
  localparam int DATA_W = NPIX * PIX_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_pixels;
  logic               out_valid;
  logic               out_ready;
  logic [PIX_W-1:0]   out_base;
  logic [BITS_W-1:0]  out_bits;
  logic [DATA_W-1:0]  out_residuals;
  logic [LVL_W-1:0]   fifo_level;
`ifdef HR_STATS_EN
  logic [31:0]        stat_blocks;
  logic [31:0]        stat_bits;
`endif

  hr_encoder_pipe #(.NPIX(NPIX), .PIX_W(PIX_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pixels(in_pixels),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_base(out_base),
    .out_bits(out_bits),
    .out_residuals(out_residuals),
    .fifo_level(fifo_level)
`ifdef HR_STATS_EN
    ,
    .stat_blocks(stat_blocks),
    .stat_bits(stat_bits)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   base;
    logic [3:0]   bits;
    logic [127:0] res;
  } blk_t;

  blk_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;
  int n_pop = 0;

  function automatic blk_t ref_model(input logic [DATA_W-1:0] pix);
    int lo = 255;
    int hi = 0;
    int p;
    int k = 0;
    blk_t b;
    for (int i = 0; i < NPIX; i++) begin
      p = int'(pix[i*8 +: 8]);
      if (p < lo) lo = p;
      if (p > hi) hi = p;
    end
    while ((1 << k) <= (hi - lo)) k++;
    b.base = 8'(lo);
    b.bits = 4'(k);
    for (int i = 0; i < NPIX; i++) begin
      p = int'(pix[i*8 +: 8]);
      b.res[i*8 +: 8] = 8'(p - lo);
    end
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] rand_block();
    logic [DATA_W-1:0] r;
    int lo;
    int w;
    int span;
    lo = int'($urandom_range(0, 255));
    w = int'($urandom_range(0, 8));
    span = (1 << w) - 1;
    if (span > 255 - lo) span = 255 - lo;
    for (int i = 0; i < NPIX; i++) r[i*8 +: 8] = 8'(lo + int'($urandom_range(0, span)));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decide transfers from the settled pre-edge values, score them, then advance one cycle.
  task automatic tick();
    bit acc;
    bit pp;
    blk_t e;
    acc = in_valid && in_ready;
    pp = out_valid && out_ready;
    if (pp) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 128'(1'b1), 128'(1'b0));
      end else begin
        e = exp_q.pop_front();
        chk("sb_base", 128'(out_base), 128'(e.base));
        chk("sb_bits", 128'(out_bits), 128'(e.bits));
        chk("sb_res", out_residuals, e.res);
      end
      n_pop++;
    end
    if (acc) begin
      exp_q.push_back(ref_model(in_pixels));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [127:0] pix, input logic [7:0] eb,
                          input logic [3:0] ebits, input logic [127:0] eres);
    in_pixels = pix;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat_e0"}, 128'(out_valid), 128'(1'b0));
    tick();
    chk({tag, "_lat_e1"}, 128'(out_valid), 128'(1'b0));
    tick();
    chk({tag, "_lat_e2"}, 128'(out_valid), 128'(1'b1));
    chk({tag, "_base"}, 128'(out_base), 128'(eb));
    chk({tag, "_bits"}, 128'(out_bits), 128'(ebits));
    chk({tag, "_res"}, out_residuals, eres);
    tick();
    chk({tag, "_one_cycle"}, 128'(out_valid), 128'(1'b0));
  endtask

  logic [127:0] pix_a;
  logic [127:0] res_a;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_pixels = '0;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_level", 128'(fifo_level), 128'(3'd0));
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    directed("flat", {16{8'h40}}, 8'h40, 4'd0, '0);

    for (int i = 0; i < NPIX; i++) begin
      pix_a[i*8 +: 8] = 8'(10 + i);
      res_a[i*8 +: 8] = 8'(i);
    end
    directed("ramp", pix_a, 8'd10, 4'd4, res_a);

    for (int i = 0; i < NPIX; i++) pix_a[i*8 +: 8] = (i % 2 == 0) ? 8'h00 : 8'hFF;
    directed("alt", pix_a, 8'h00, 4'd8, pix_a);

    // Backpressure: only FIFO_DEPTH blocks may be in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_pixels = rand_block();
      tick();
    end
    chk("bp_accepts", 128'(n_acc), 128'(FIFO_DEPTH));
    chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
    chk("bp_level", 128'(fifo_level), 128'(3'd4));
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("bp_consecutive", 128'(out_valid), 128'(1'b1));
      tick();
      if (c == 0) chk("bp_ready_after_pop", 128'(in_ready), 128'(1'b1));
    end
    chk("bp_drained_valid", 128'(out_valid), 128'(1'b0));
    chk("bp_drained_q", 128'(exp_q.size()), 128'(0));

    // Full throughput with the consumer always ready.
    n_acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_pixels = rand_block();
      tick();
    end
    chk("tp_accepts", 128'(n_acc), 128'(40));
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("tp_drained_q", 128'(exp_q.size()), 128'(0));
    chk("tp_drained_valid", 128'(out_valid), 128'(1'b0));

    // Random handshakes on both sides.
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_pixels = rand_block();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("rand_drained_q", 128'(exp_q.size()), 128'(0));

    // Reset with two blocks buffered and more in the pipe.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_pixels = rand_block();
      tick();
    end
    in_valid = 1'b0;
    chk("mid_level_pre", 128'(fifo_level), 128'(3'd2));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(1'b0));
    chk("mid_rst_level", 128'(fifo_level), 128'(3'd0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
    exp_q.delete();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_rst_quiet", 128'(out_valid), 128'(1'b0));
    end

`ifdef HR_STATS_EN
    directed("st0", {16{8'h40}}, 8'h40, 4'd0, '0);
    for (int i = 0; i < NPIX; i++) begin
      pix_a[i*8 +: 8] = 8'(10 + i);
      res_a[i*8 +: 8] = 8'(i);
    end
    directed("st4", pix_a, 8'd10, 4'd4, res_a);
    for (int i = 0; i < NPIX; i++) pix_a[i*8 +: 8] = (i % 2 == 0) ? 8'h00 : 8'hFF;
    directed("st8", pix_a, 8'h00, 4'd8, pix_a);
    chk("stat_blocks", 128'(stat_blocks), 128'(32'd3));
    chk("stat_bits", 128'(stat_bits), 128'(32'd228));
    #1 rst = 1'b1;
    #1;
    chk("stat_blocks_rst", 128'(stat_blocks), 128'(32'd0));
    chk("stat_bits_rst", 128'(stat_bits), 128'(32'd0));
    #1 rst = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
